// File: rtl/pe_result_drain_pkg.sv
// Shared definitions for the PE result drain.
// Holds the default sizing of the MAC chain result path, the drain FSM
// state encodings and a small elaboration-time helper for the depth check.
package pe_result_drain_pkg;

    localparam int default_data_width      = 32;
    localparam int default_pipeline_stages = 12;   // MUL 5 + ADD 7
    localparam int default_buffer_width    = 5;
    localparam int default_buffer_size     = 32;
    localparam int default_count_width     = 16;

    localparam logic [1:0] st_idle    = 2'd0;
    localparam logic [1:0] st_collect = 2'd1;
    localparam logic [1:0] st_flush   = 2'd2;

    // The FIFO must be able to absorb every in-flight result plus one
    // more beyond the point where the issue permit drops.
    function automatic bit depth_ok(input int size, input int stages);
        return size > stages + 1;
    endfunction

endpackage

// File: rtl/pe_result_drain_fifo.sv
// Result FIFO for the PE drain.
// Words arriving from the PE cannot be back-pressured, so this FIFO accepts
// a write whenever there is room (or a read frees a slot in the same cycle)
// and flags a sticky overflow when a word has to be dropped.
// Ports:
//   clk, aclr    clock, asynchronous active-low reset
//   wr_data/wr_valid   incoming result word
//   rd_data/rd_valid   head word (combinational from memory), rd_ready pops
//   push/pop     this cycle's accepted write / read
//   level        registered occupancy, level_next occupancy after this cycle
//   overflow     sticky: a word arrived while full with no pop
module pe_result_drain_fifo #(
    parameter int DataWidth   = 32,
    parameter int BufferWidth = 5,
    parameter int BufferSize  = 32
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic [DataWidth-1:0] wr_data,
    input  logic                 wr_valid,
    input  logic                 rd_ready,
    output logic [DataWidth-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 push,
    output logic                 pop,
    output logic [BufferWidth:0] level,
    output logic [BufferWidth:0] level_next,
    output logic                 overflow
);

    localparam int LevelW = BufferWidth + 1;

    logic [DataWidth-1:0]   mem [BufferSize];
    logic [BufferWidth-1:0] wr_ptr;
    logic [BufferWidth-1:0] rd_ptr;
    logic                   full;
    logic                   empty;

    function automatic logic [BufferWidth-1:0] ptr_inc(input logic [BufferWidth-1:0] p);
        return (p == BufferWidth'(BufferSize - 1)) ? '0 : p + BufferWidth'(1);
    endfunction

    assign full     = (level == LevelW'(BufferSize));
    assign empty    = (level == '0);
    assign rd_valid = !empty;
    assign pop      = rd_valid && rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push     = wr_valid && (!full || pop);

    // Gate the head word so the port reads zero while nothing is buffered.
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + LevelW'(1);
        end else if (pop && !push) begin
            level_next = level - LevelW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            level <= level_next;
            if (wr_valid && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_result_drain.sv
// Terminal receiver on the partial-sum output stream of the last PE in a
// MAC chain. Issues the PE's permit only while the FIFO has room for every
// result that could still be in flight, re-times results onto a host
// valid/ready port, counts results per job and pulses Done at completion.
// Ports:
//   clk, aclr                     clock, asynchronous active-low reset
//   O_DataIn, O_DataInValid       result stream from the last PE
//   O_DataOutRdy                  issue permit to the last PE
//   Start, Num_Results            job launch and expected result count
//   R_DataOut, R_DataOutValid,
//   R_DataOutRdy                  host result port
//   Busy, Done, Overflow          job status, completion pulse, sticky drop flag
//
// state   | meaning
// IDLE    | no job; Start with a nonzero count opens COLLECT, zero goes to FLUSH
// COLLECT | permit may be issued; every accepted result counts toward target
// FLUSH   | all results received; wait for the FIFO to drain, then Done
module pe_result_drain
    import pe_result_drain_pkg::*;
#(
    parameter int DataWidth       = default_data_width,
    parameter int Pipeline_Stages = default_pipeline_stages,
    parameter int BufferWidth     = default_buffer_width,
    parameter int BufferSize      = default_buffer_size,
    parameter int CountWidth      = default_count_width
) (
    input  logic                  clk,
    input  logic                  aclr,
    input  logic [DataWidth-1:0]  O_DataIn,
    input  logic                  O_DataInValid,
    output logic                  O_DataOutRdy,
    input  logic                  Start,
    input  logic [CountWidth-1:0] Num_Results,
    output logic [DataWidth-1:0]  R_DataOut,
    output logic                  R_DataOutValid,
    input  logic                  R_DataOutRdy,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Overflow
);

    localparam int LevelW   = BufferWidth + 1;
    // Once occupancy reaches this value, the results already in the MAC
    // pipeline could fill the remaining slots, so the permit must drop.
    localparam int RdyLimit = BufferSize - Pipeline_Stages - 1;

    generate
        if (!depth_ok(BufferSize, Pipeline_Stages)) begin : g_bad_depth
            $error("pe_result_drain: BufferSize must exceed Pipeline_Stages+1");
        end
        if (BufferSize > (1 << BufferWidth)) begin : g_bad_width
            $error("pe_result_drain: BufferWidth too small for BufferSize");
        end
    endgenerate

    logic [1:0]            state;
    logic [CountWidth-1:0] rcv;
    logic [CountWidth-1:0] target;
    logic [CountWidth-1:0] rcv_inc;
    logic                  push;
    logic                  pop;
    logic [BufferWidth:0]  level;
    logic [BufferWidth:0]  level_next;

    pe_result_drain_fifo #(
        .DataWidth   (DataWidth),
        .BufferWidth (BufferWidth),
        .BufferSize  (BufferSize)
    ) u_fifo (
        .clk        (clk),
        .aclr       (aclr),
        .wr_data    (O_DataIn),
        .wr_valid   (O_DataInValid),
        .rd_ready   (R_DataOutRdy),
        .rd_data    (R_DataOut),
        .rd_valid   (R_DataOutValid),
        .push       (push),
        .pop        (pop),
        .level      (level),
        .level_next (level_next),
        .overflow   (Overflow)
    );

    // Saturate rather than wrap so a runaway stream can never fake a match.
    assign rcv_inc      = (rcv == {CountWidth{1'b1}}) ? rcv : rcv + CountWidth'(1);

    assign O_DataOutRdy = (state == st_collect) && (level < LevelW'(RdyLimit));
    assign Busy         = (state != st_idle);

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state  <= st_idle;
            rcv    <= '0;
            target <= '0;
            Done   <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                st_idle: begin
                    if (Start) begin
                        rcv    <= '0;
                        target <= Num_Results;
                        state  <= (Num_Results == '0) ? st_flush : st_collect;
                    end
                end
                st_collect: begin
                    if (push) begin
                        rcv <= rcv_inc;
                        if (rcv_inc == target) begin
                            state <= st_flush;
                        end
                    end
                end
                st_flush: begin
                    // Includes this cycle's pop so Done follows the last word directly.
                    if (level_next == '0) begin
                        state <= st_idle;
                        Done  <= 1'b1;
                    end
                end
                default: begin
                    state <= st_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_result_drain.sv
// Bench for pe_result_drain: a 12-stage PE model honouring the issue permit,
// a host model with programmable hold-off, a job table and hand-written
// sequences for reset, forced overflow and mid-job reset.
module tb_pe_result_drain;

    localparam int PS = 12;

    logic        clk = 1'b0;
    logic        aclr = 1'b0;
    logic [31:0] O_DataIn;
    logic        O_DataInValid;
    logic        O_DataOutRdy;
    logic        Start = 1'b0;
    logic [15:0] Num_Results = '0;
    logic [31:0] R_DataOut;
    logic        R_DataOutValid;
    logic        R_DataOutRdy = 1'b0;
    logic        Busy;
    logic        Done;
    logic        Overflow;

    logic        force_mode = 1'b0;
    logic        f_valid = 1'b0;
    logic [31:0] f_data = '0;
    logic        pe_valid = 1'b0;
    logic [31:0] pe_data = '0;

    int          issued = 0;
    int          pe_total = 0;
    logic [PS-1:0] pipe_v = '0;
    logic [31:0] pipe_d [PS];
    logic [31:0] exp_q [$];

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        int num;
        int hold;
        bit restart;
        bit exp_saw18;
        bit exp_no_rdy;
    } job_t;

    job_t jobs [4];

    assign O_DataInValid = force_mode ? f_valid : pe_valid;
    assign O_DataIn      = force_mode ? f_data  : pe_data;

    pe_result_drain dut (
        .clk            (clk),
        .aclr           (aclr),
        .O_DataIn       (O_DataIn),
        .O_DataInValid  (O_DataInValid),
        .O_DataOutRdy   (O_DataOutRdy),
        .Start          (Start),
        .Num_Results    (Num_Results),
        .R_DataOut      (R_DataOut),
        .R_DataOutValid (R_DataOutValid),
        .R_DataOutRdy   (R_DataOutRdy),
        .Busy           (Busy),
        .Done           (Done),
        .Overflow       (Overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input int i);
        case (i)
            0:       return 32'h3F80_0000;
            1:       return 32'h4000_0000;
            2:       return 32'h4040_0000;
            3:       return 32'h4080_0000;
            default: return 32'hC0DE_0000 + 32'(i);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // PE model: a permit seen during cycle n issues at the following edge and
    // the result is pushed exactly PS edges later.
    always @(negedge clk) begin
        if (!aclr) begin
            pipe_v   = '0;
            pe_valid = 1'b0;
            pe_data  = '0;
            issued   = 0;
            pe_total = 0;
        end else begin
            pe_valid = pipe_v[PS-1];
            pe_data  = pipe_d[PS-1];
            for (int i = PS - 1; i > 0; i--) begin
                pipe_v[i] = pipe_v[i-1];
                pipe_d[i] = pipe_d[i-1];
            end
            pipe_v[0] = O_DataOutRdy && (issued < pe_total);
            pipe_d[0] = word_of(issued);
            if (pipe_v[0]) begin
                exp_q.push_back(word_of(issued));
                issued++;
            end
        end
    end

    task automatic run_job(input job_t j);
        int  words = 0;
        int  done_cnt = 0;
        int  done_cyc = -1;
        int  last_pop_cyc = -1;
        int  rdy_cycles = 0;
        int  rdy_viol = 0;
        int  busy_at_done = 0;
        int  peak = 0;
        bit  saw18 = 1'b0;
        bit  busy1 = 1'b0;
        bit  finished = 1'b0;
        int  cyc;
        @(negedge clk);
        issued   = 0;
        pe_total = j.num;
        for (cyc = 0; cyc < 3000 && !finished; cyc++) begin
            Start        = (cyc == 0) || (j.restart && cyc == 6);
            Num_Results  = (cyc == 0) ? 16'(j.num) : 16'd7;
            R_DataOutRdy = (cyc >= j.hold);
            if (cyc == 1) busy1 = Busy;
            if (O_DataOutRdy) begin
                rdy_cycles++;
                if (int'(dut.level) > 18 || !Busy) rdy_viol++;
                if (int'(dut.level) == 18) saw18 = 1'b1;
            end
            if (int'(dut.level) > peak) peak = int'(dut.level);
            if (Done) begin
                done_cnt++;
                done_cyc = cyc;
                if (Busy) busy_at_done++;
            end
            if (R_DataOutValid && R_DataOutRdy) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 64'(R_DataOut), 64'hDEAD_BEEF_DEAD_BEEF);
                end else begin
                    check("job_data", 64'(R_DataOut), 64'(exp_q.pop_front()));
                end
                words++;
                last_pop_cyc = cyc;
            end
            if (done_cnt > 0 && cyc >= done_cyc + 3) finished = 1'b1;
            @(negedge clk);
        end
        Start = 1'b0;
        check("job_finished", 64'(finished), 64'd1);
        check("job_words", 64'(words), 64'(j.num));
        check("job_done_count", 64'(done_cnt), 64'd1);
        if (j.num == 0) check("done_latency_zero", 64'(done_cyc), 64'd2);
        else            check("done_after_last_pop", 64'(done_cyc - last_pop_cyc), 64'd1);
        check("busy_cycle1", 64'(busy1), 64'd1);
        check("busy_low_at_done", 64'(busy_at_done), 64'd0);
        check("busy_end", 64'(Busy), 64'd0);
        check("rdy_violations", 64'(rdy_viol), 64'd0);
        check("peak_le_31", 64'(peak <= 31), 64'd1);
        check("saw_rdy_at_18", 64'(saw18), 64'(j.exp_saw18));
        if (j.exp_no_rdy) check("no_rdy_zero_job", 64'(rdy_cycles), 64'd0);
        check("job_overflow", 64'(Overflow), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int words;
        int cyc;

        jobs[0] = '{num: 4,  hold: 0,   restart: 1'b1, exp_saw18: 1'b0, exp_no_rdy: 1'b0};
        jobs[1] = '{num: 40, hold: 120, restart: 1'b0, exp_saw18: 1'b1, exp_no_rdy: 1'b0};
        jobs[2] = '{num: 0,  hold: 0,   restart: 1'b0, exp_saw18: 1'b0, exp_no_rdy: 1'b1};
        jobs[3] = '{num: 7,  hold: 3,   restart: 1'b0, exp_saw18: 1'b0, exp_no_rdy: 1'b0};

        // Reset: held low for three cycles.
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({O_DataOutRdy, R_DataOutValid, Busy, Done, Overflow}), 64'd0);
        check("reset_rdata", 64'(R_DataOut), 64'd0);
        check("reset_level", 64'(dut.level), 64'd0);
        aclr = 1'b1;
        @(negedge clk);
        check("post_reset_rdy", 64'(O_DataOutRdy), 64'd0);
        check("post_reset_busy", 64'(Busy), 64'd0);
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_job(jobs[i]);
        end

        // Forced overflow: 33 words with the host stalled and no permits.
        @(negedge clk);
        force_mode   = 1'b1;
        R_DataOutRdy = 1'b0;
        for (int k = 0; k < 33; k++) begin
            f_valid = 1'b1;
            f_data  = 32'hF000_0000 + 32'(k);
            @(negedge clk);
            if (k == 31) begin
                check("ovf_level_full", 64'(dut.level), 64'd32);
                check("ovf_not_yet", 64'(Overflow), 64'd0);
            end
        end
        f_valid = 1'b0;
        check("ovf_set", 64'(Overflow), 64'd1);
        check("ovf_level_held", 64'(dut.level), 64'd32);
        repeat (5) @(negedge clk);
        check("ovf_sticky", 64'(Overflow), 64'd1);
        R_DataOutRdy = 1'b1;
        for (int k = 0; k < 32; k++) begin
            check("ovf_drain_data", 64'(R_DataOut), 64'(32'hF000_0000 + 32'(k)));
            @(negedge clk);
        end
        check("ovf_drained_valid", 64'(R_DataOutValid), 64'd0);
        check("ovf_sticky_after_drain", 64'(Overflow), 64'd1);
        check("ovf_idle_busy", 64'(Busy), 64'd0);
        #2 aclr = 1'b0;
        #1 check("ovf_cleared_by_reset", 64'(Overflow), 64'd0);
        force_mode = 1'b0;
        repeat (2) @(negedge clk);
        aclr = 1'b1;

        // Mid-job reset after 5 of 10 results.
        @(negedge clk);
        issued       = 0;
        pe_total     = 10;
        Start        = 1'b1;
        Num_Results  = 16'd10;
        R_DataOutRdy = 1'b1;
        words = 0;
        cyc   = 0;
        while (words < 5 && cyc < 500) begin
            @(negedge clk);
            Start = 1'b0;
            cyc++;
            if (R_DataOutValid && R_DataOutRdy) begin
                check("midjob_data", 64'(R_DataOut), 64'(exp_q.pop_front()));
                words++;
            end
        end
        check("midjob_reached_5", 64'(words), 64'd5);
        @(posedge clk);
        #2 aclr = 1'b0;
        #1;
        check("midjob_reset_outputs", 64'({O_DataOutRdy, R_DataOutValid, Busy, Done, Overflow}), 64'd0);
        check("midjob_reset_rdata", 64'(R_DataOut), 64'd0);
        check("midjob_reset_level", 64'(dut.level), 64'd0);
        repeat (3) @(negedge clk);
        #1 exp_q.delete();
        @(negedge clk);
        aclr = 1'b1;
        run_job('{num: 3, hold: 0, restart: 1'b0, exp_saw18: 1'b0, exp_no_rdy: 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
